imem_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the synchronous instruction memory for the multi-cycle/pipelined MIPS core. It owns the fetch PC, issues word reads into the 1-cycle-latency IMem and pairs each returned instruction with its PC. Results are buffered in a 2-entry queue and delivered to decode over a valid/ready handshake. Branch/jump redirects flush the queue and any read still in flight.

---
 rtl/imem_fetch_pkg.sv | 15 +
 rtl/imem_fetch_ctrl_if.sv | 10 +
 rtl/imem_fetch_ctrl_fetch_buf2.sv | 49 ++++
 rtl/imem_fetch_ctrl.sv | 95 +++++++++
 tb/tb_imem_fetch_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package imem_fetch_pkg;
  localparam int          IMEM_AW_DEF  = 7;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction
endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-to-decode valid/ready handshake carrying {pc, ir}.
interface imem_fetch_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ir;

  modport master (output out_valid, output out_pc, output out_ir, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_ir, output out_ready);
endinterface

// File: rtl/imem_fetch_ctrl_fetch_buf2.sv
// Two-entry FIFO of fetch_entry_t; flush overrides push and pop.
module fetch_buf2
  import imem_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   occ
);
  fetch_entry_t entry_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   occ_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          entry_reg[gi] <= '0;
        else if (push && !flush && (wr_ptr_reg == 1'(gi)))
          entry_reg[gi] <= push_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = entry_reg[rd_ptr_reg];
  assign occ  = occ_reg;
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch PC, one outstanding IMem read and credit-limited 2-entry delivery queue.
// Optional perf counters are built when IMEM_FETCH_PERF_EN is defined.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int          IMEM_AW  = IMEM_AW_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  imem_fetch_ctrl_if.master  dec
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic         req_valid_reg, req_valid_next;
  logic [31:0]  req_pc_reg, req_pc_next;
  logic [1:0]   occ;
  logic [2:0]   credit;
  logic         pop, push, issue;
  fetch_entry_t head;

  assign pop    = dec.out_valid & dec.out_ready;
  assign push   = req_valid_reg & ~redirect_valid;
  // Entries held plus the read in flight must leave room after this cycle's pop.
  assign credit = {1'b0, occ} + {2'b00, req_valid_reg};
  assign issue  = ~halt & ~redirect_valid & (credit < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg  <= RESET_PC;
      req_valid_reg <= 1'b0;
      req_pc_reg    <= 32'd0;
    end else begin
      fetch_pc_reg  <= fetch_pc_next;
      req_valid_reg <= req_valid_next;
      req_pc_reg    <= req_pc_next;
    end
  end

  always_comb begin
    fetch_pc_next  = fetch_pc_reg;
    req_valid_next = 1'b0;
    req_pc_next    = req_pc_reg;
    if (redirect_valid) begin
      fetch_pc_next = word_align(redirect_pc);
    end else if (issue) begin
      req_valid_next = 1'b1;
      req_pc_next    = fetch_pc_reg;
      fetch_pc_next  = fetch_pc_reg + PC_STEP;
    end
  end

  fetch_buf2 u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: req_pc_reg, ir: imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .occ       (occ)
  );

  assign imem_addr     = fetch_pc_reg[IMEM_AW+1:2];
  assign dec.out_valid = (occ != 2'd0) & ~redirect_valid;
  assign dec.out_pc    = head.pc;
  assign dec.out_ir    = head.ir;

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_reg;
  logic [31:0] perf_stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt_reg <= 32'd0;
      perf_stall_cnt_reg <= 32'd0;
    end else begin
      if (push)                           perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
      if (dec.out_ready && !dec.out_valid) perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_reg;
  assign perf_stall_cnt = perf_stall_cnt_reg;
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed table, reset corner cases,
// and randomized traffic against a queue-based reference model.
module tb_imem_fetch_ctrl;
  import imem_fetch_pkg::*;

  localparam int          AW   = 7;
  localparam logic [31:0] RPC0 = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          halt = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  imem_fetch_ctrl_if dec_if ();

  imem_fetch_ctrl #(.IMEM_AW(AW), .RESET_PC(RPC0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dec_if.master)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous 1-cycle-latency instruction memory.
  logic [31:0] mem [128];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a list of delivered-but-unconsumed words plus one pending read.
  fetch_entry_t m_q[$];
  bit           m_pend;
  logic [31:0]  m_pend_pc;
  logic [31:0]  m_fpc;
  logic [31:0]  m_fetch;
  logic [31:0]  m_stall;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return mem[pc[AW+1:2]];
  endfunction

  function automatic bit m_valid();
    return (m_q.size() != 0) && !redirect_valid;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend  = 0;
    m_pend_pc = 32'd0;
    m_fpc   = RPC0;
    m_fetch = 32'd0;
    m_stall = 32'd0;
  endtask

  task automatic model_step();
    bit pop_m;
    int room;
    pop_m = m_valid() && dec_if.out_ready;
    if (dec_if.out_ready && !m_valid()) m_stall++;
    if (redirect_valid) begin
      m_q.delete();
      m_pend = 0;
      m_fpc  = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      room = m_q.size() + int'(m_pend) - int'(pop_m);
      if (pop_m) void'(m_q.pop_front());
      if (m_pend) begin
        m_q.push_back('{pc: m_pend_pc, ir: word_at(m_pend_pc)});
        m_fetch++;
      end
      if (!halt && room < 2) begin
        m_pend    = 1;
        m_pend_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end else begin
        m_pend = 0;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input bit use_row, input bit ev, input logic [31:0] epc, input int exp_addr);
    @(negedge clk);
    chk("out_valid", 32'(dec_if.out_valid), 32'(m_valid()));
    if (m_valid()) begin
      chk("out_pc", dec_if.out_pc, m_q[0].pc);
      chk("out_ir", dec_if.out_ir, m_q[0].ir);
    end
    chk("imem_addr", 32'(imem_addr), 32'(m_fpc[AW+1:2]));
`ifdef IMEM_FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, m_fetch);
    chk("perf_stall", perf_stall_cnt, m_stall);
`endif
    if (use_row) begin
      chk("row_valid", 32'(dec_if.out_valid), 32'(ev));
      if (ev) begin
        chk("row_pc", dec_if.out_pc, epc);
        chk("row_ir", dec_if.out_ir, word_at(epc));
      end
    end
    if (exp_addr >= 0) chk("addr_stable", 32'(imem_addr), 32'(exp_addr));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(dec_if.out_valid), 32'd0);
    chk("rst_pc", dec_if.out_pc, 32'd0);
    chk("rst_ir", dec_if.out_ir, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'(RPC0[AW+1:2]));
`ifdef IMEM_FETCH_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    bit          h;
    bit          r;
    logic [31:0] rpc;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
  } row_t;

  row_t rows[23];

  task automatic put(input int i, input bit h, input bit r, input logic [31:0] rpc,
                     input bit rdy, input bit ev, input logic [31:0] epc);
    rows[i] = '{h: h, r: r, rpc: rpc, rdy: rdy, ev: ev, epc: epc};
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = (32'h9E37_79B9 * 32'(i + 1)) ^ (32'(i) << 16);
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    dec_if.out_ready = 1'b0;

    // Stream, backpressure, redirect to 0x43, halt window, resume.
    put(0,  0, 0, 0, 1, 0, 32'h00);
    put(1,  0, 0, 0, 1, 0, 32'h00);
    put(2,  0, 0, 0, 1, 1, 32'h00);
    put(3,  0, 0, 0, 0, 1, 32'h04);
    for (int i = 4; i < 8; i++) put(i, 0, 0, 0, 0, 1, 32'h04);
    put(8,  0, 0, 0, 1, 1, 32'h04);
    put(9,  0, 0, 0, 1, 1, 32'h08);
    put(10, 0, 0, 0, 1, 1, 32'h0C);
    put(11, 0, 1, 32'h43, 1, 0, 32'h00);
    put(12, 0, 0, 0, 1, 0, 32'h00);
    put(13, 0, 0, 0, 1, 0, 32'h00);
    put(14, 0, 0, 0, 1, 1, 32'h40);
    put(15, 1, 0, 0, 1, 1, 32'h44);
    put(16, 1, 0, 0, 1, 1, 32'h48);
    put(17, 1, 0, 0, 1, 0, 32'h00);
    put(18, 1, 0, 0, 1, 0, 32'h00);
    put(19, 0, 0, 0, 1, 0, 32'h00);
    put(20, 0, 0, 0, 1, 0, 32'h00);
    put(21, 0, 0, 0, 1, 1, 32'h4C);
    put(22, 0, 0, 0, 1, 1, 32'h50);

    @(posedge clk);
    #1;
    pulse_reset();

    for (int i = 0; i < 23; i++) begin
      halt             = rows[i].h;
      redirect_valid   = rows[i].r;
      redirect_pc      = rows[i].rpc;
      dec_if.out_ready = rows[i].rdy;
      cycle(1'b1, rows[i].ev, rows[i].epc, (i >= 3 && i <= 7) ? 3 : -1);
    end

    // Fill the queue, then reset asynchronously mid-stream.
    halt = 0; redirect_valid = 0; dec_if.out_ready = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, -1);
    pulse_reset();
    dec_if.out_ready = 1;
    cycle(1'b1, 1'b0, 32'd0, -1);
    cycle(1'b1, 1'b0, 32'd0, -1);
    cycle(1'b1, 1'b1, RPC0, -1);
    cycle(1'b1, 1'b1, RPC0 + 32'd4, -1);

    // Randomized traffic, including redirects near the top of the address space.
    for (int i = 0; i < 600; i++) begin
      halt             = ($urandom_range(0, 7) == 0);
      redirect_valid   = ($urandom_range(0, 15) == 0);
      redirect_pc      = ($urandom_range(0, 1) == 0) ? $urandom()
                                                     : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      dec_if.out_ready = ($urandom_range(0, 3) != 0);
      cycle(1'b0, 1'b0, 32'd0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
